// File: rtl/ac_motor_pwm.sv
// ac_motor_pwm: symmetric triangle-carrier PWM for one half-bridge leg; period/duty shadows reload at the valley.
// Optional macro AC_MOTOR_PWM_MIN_PULSE_EN clamps duty so no pulse or gap is narrower than MIN_PULSE.
module ac_motor_pwm #(
   parameter int WIDTH     = 11,
   parameter int MIN_PULSE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   output logic             s_out,
   output logic             carrier_zero,
   output logic             carrier_peak,
   output logic [WIDTH-1:0] count
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   logic [WIDTH-1:0] count_q, count_d;
   dir_t             dir_q, dir_d;
   logic [WIDTH-1:0] period_sh_q, period_sh_d;
   logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic             s_out_q, s_out_d;
   logic             zero_q, zero_d;
   logic             peak_q, peak_d;
   logic             running;
   logic             shadow_load;
   logic [WIDTH-1:0] duty_eff;

`ifdef AC_MOTOR_PWM_MIN_PULSE_EN
   localparam logic [WIDTH-1:0] MinPulse = WIDTH'(MIN_PULSE);
   logic [WIDTH-1:0] gap;

   assign gap = period - duty;

   always_comb begin
      duty_eff = duty;
      if (duty < MinPulse) begin
         duty_eff = '0;
      end else if (gap < MinPulse) begin
         duty_eff = period;
      end
   end
`else
   localparam bit min_pulse_unused = (MIN_PULSE > 0);

   assign duty_eff = duty;
`endif

   assign running     = enable && (period_sh_q != '0);
   // Reload on the edge that brings the carrier back to 0, so a carrier never mixes old and new values.
   assign shadow_load = reset || !enable || (period_sh_q == '0)
                        || ((dir_q == DIR_DOWN) && (count_q == WIDTH'(1)));

   always_comb begin
      count_d     = count_q;
      dir_d       = dir_q;
      period_sh_d = period_sh_q;
      duty_sh_d   = duty_sh_q;
      if (shadow_load) begin
         period_sh_d = period;
         duty_sh_d   = duty_eff;
      end
      if (!running) begin
         count_d = '0;
         dir_d   = DIR_UP;
      end else if (dir_q == DIR_UP) begin
         count_d = count_q + WIDTH'(1);
         if (count_d == period_sh_q) dir_d = DIR_DOWN;
      end else begin
         count_d = count_q - WIDTH'(1);
         if (count_d == '0) dir_d = DIR_UP;
      end
   end

   // Comparing on the down slope with equality makes the high time exactly 2*D, centred on the valley.
   always_comb begin
      s_out_d = running && ((count_q < duty_sh_q)
                            || ((dir_q == DIR_DOWN) && (count_q == duty_sh_q))
                            || (duty_sh_q > period_sh_q));
      zero_d  = enable && (count_q == '0);
      peak_d  = running && (count_q == period_sh_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         dir_q       <= DIR_UP;
         period_sh_q <= period;
         duty_sh_q   <= duty_eff;
         s_out_q     <= 1'b0;
         zero_q      <= 1'b0;
         peak_q      <= 1'b0;
      end else begin
         count_q     <= count_d;
         dir_q       <= dir_d;
         period_sh_q <= period_sh_d;
         duty_sh_q   <= duty_sh_d;
         s_out_q     <= s_out_d;
         zero_q      <= zero_d;
         peak_q      <= peak_d;
      end
   end

   assign s_out        = s_out_q;
   assign carrier_zero = zero_q;
   assign carrier_peak = peak_q;
   assign count        = count_q;

endmodule

// File: tb/tb_ac_motor_pwm.sv
// tb_ac_motor_pwm: directed checks of carrier sequence, duty shadowing, enable/reset/period-0 behaviour.
module tb_ac_motor_pwm;

   localparam int W = 11;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [W-1:0] period;
   logic [W-1:0] duty;
   logic         s_out;
   logic         carrier_zero;
   logic         carrier_peak;
   logic [W-1:0] count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      int p;
      int d;
      int n;
      int hi;
      int pk;
      int zc;
   } vec_t;

   vec_t vecs[12];

   ac_motor_pwm #(.WIDTH(W), .MIN_PULSE(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .period       (period),
      .duty         (duty),
      .s_out        (s_out),
      .carrier_zero (carrier_zero),
      .carrier_peak (carrier_peak),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Expected value for the default build, or for the min-pulse clamped build.
   function automatic int sel(input int dflt, input int clamped);
`ifdef AC_MOTOR_PWM_MIN_PULSE_EN
      return clamped;
`else
      return dflt;
`endif
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input int p, input int d);
      period = W'(p);
      duty   = W'(d);
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
   endtask

   task automatic run_win(input int n, output int hi, output int pk, output int zc);
      hi = 0;
      pk = 0;
      zc = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         hi += int'(s_out);
         pk += int'(carrier_peak);
         zc += int'(carrier_zero);
      end
   endtask

   initial begin
      int exp_cnt[6];
      int s_pat[6];
      int pk_pat[6];
      int z_pat[6];
      int hi, pk, zc;

      exp_cnt = '{1, 2, 3, 2, 1, 0};
      s_pat   = '{1, 0, 0, 0, 0, 1};
      pk_pat  = '{0, 0, 0, 1, 0, 0};
      z_pat   = '{1, 0, 0, 0, 0, 0};

      reset  = 1'b1;
      enable = 1'b1;
      period = W'(3);
      duty   = W'(1);
      repeat (3) tick();
      check_val("rst_count", 32'(count), 0);
      check_val("rst_s_out", 32'(s_out), 0);
      check_val("rst_zero", 32'(carrier_zero), 0);
      check_val("rst_peak", 32'(carrier_peak), 0);

      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val($sformatf("seq%0d_count", i), 32'(count), 32'(exp_cnt[i]));
         check_val($sformatf("seq%0d_s_out", i), 32'(s_out), 32'(sel(s_pat[i], 0)));
         check_val($sformatf("seq%0d_peak", i), 32'(carrier_peak), 32'(pk_pat[i]));
         check_val($sformatf("seq%0d_zero", i), 32'(carrier_zero), 32'(z_pat[i]));
      end

      // Duty rewritten mid-carrier at count 5 on the up slope.
      restart(10, 4);
      hi = 0;
      pk = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         hi += int'(s_out);
         pk += int'(carrier_peak);
         if (i == 5) begin
            check_val("mid_count5", 32'(count), 5);
            duty = W'(7);
         end
      end
      check_val("mid_old_hi", 32'(hi), 8);
      check_val("mid_old_pk", 32'(pk), 1);
      check_val("mid_valley", 32'(count), 0);
      run_win(20, hi, pk, zc);
      check_val("mid_new_hi", 32'(hi), 32'(sel(14, 20)));
      check_val("mid_new_pk", 32'(pk), 1);

      // Enable dropped at count 6, then re-enabled with new duty.
      restart(10, 4);
      repeat (6) tick();
      check_val("en_count6", 32'(count), 6);
      enable = 1'b0;
      tick();
      check_val("en_off_count", 32'(count), 0);
      check_val("en_off_s_out", 32'(s_out), 0);
      check_val("en_off_zero", 32'(carrier_zero), 0);
      check_val("en_off_peak", 32'(carrier_peak), 0);
      duty = W'(9);
      tick();
      check_val("en_off_hold", 32'(count), 0);
      enable = 1'b1;
      tick();
      check_val("en_on_count", 32'(count), 1);
      check_val("en_on_s_out", 32'(s_out), 1);
      check_val("en_on_zero", 32'(carrier_zero), 1);
      run_win(20, hi, pk, zc);
      check_val("en_on_hi", 32'(hi), 32'(sel(18, 20)));
      check_val("en_on_pk", 32'(pk), 1);
      check_val("en_on_zc", 32'(zc), 1);

      // Period 0 halts the carrier; a nonzero period starts it right away.
      restart(0, 4);
      run_win(10, hi, pk, zc);
      check_val("p0_hi", 32'(hi), 0);
      check_val("p0_pk", 32'(pk), 0);
      check_val("p0_zc", 32'(zc), 10);
      check_val("p0_count", 32'(count), 0);
      period = W'(5);
      tick();
      check_val("p5_first_count", 32'(count), 0);
      tick();
      check_val("p5_second_count", 32'(count), 1);
      check_val("p5_s_out", 32'(s_out), 1);

      // Period set to 0 mid-carrier: finishes the carrier, then halts.
      restart(3, 1);
      period = W'(0);
      run_win(6, hi, pk, zc);
      check_val("stop_valley", 32'(count), 0);
      check_val("stop_last_pk", 32'(pk), 1);
      run_win(8, hi, pk, zc);
      check_val("stop_count", 32'(count), 0);
      check_val("stop_hi", 32'(hi), 0);
      check_val("stop_pk", 32'(pk), 0);
      check_val("stop_zc", 32'(zc), 8);

      // Reset in mid-carrier restarts from the valley.
      restart(10, 4);
      repeat (7) tick();
      reset = 1'b1;
      tick();
      check_val("mrst_count", 32'(count), 0);
      check_val("mrst_s_out", 32'(s_out), 0);
      reset = 1'b0;
      tick();
      check_val("mrst_next", 32'(count), 1);

      vecs[0]  = '{3,   1,   12,  sel(4, 0),     2,  2};
      vecs[1]  = '{10,  4,   20,  8,             1,  1};
      vecs[2]  = '{10,  0,   20,  0,             1,  1};
      vecs[3]  = '{10,  9,   20,  sel(18, 20),   1,  1};
      vecs[4]  = '{10,  10,  20,  20,            1,  1};
      vecs[5]  = '{10,  200, 20,  20,            1,  1};
      vecs[6]  = '{1,   1,   20,  sel(20, 0),    10, 10};
      vecs[7]  = '{2,   1,   20,  sel(10, 0),    5,  5};
      vecs[8]  = '{1,   0,   20,  0,             10, 10};
      vecs[9]  = '{100, 2,   200, sel(4, 0),     1,  1};
      vecs[10] = '{100, 98,  200, sel(196, 200), 1,  1};
      vecs[11] = '{100, 50,  200, 100,           1,  1};

      for (int v = 0; v < 12; v++) begin
         restart(vecs[v].p, vecs[v].d);
         run_win(vecs[v].n, hi, pk, zc);
         check_val($sformatf("vec%0d_hi", v), 32'(hi), 32'(vecs[v].hi));
         check_val($sformatf("vec%0d_pk", v), 32'(pk), 32'(vecs[v].pk));
         check_val($sformatf("vec%0d_zc", v), 32'(zc), 32'(vecs[v].zc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
